color_freq_sampler: RTL

Front-end stage that feeds the colour classifier. It drives the colour sensor's photodiode filter-select pins (S2/S3) through red, green, blue and clear in turn. For each filter it counts rising edges of the sensor's frequency output over a fixed gate window, then presents all four counts together as one frame with a single-cycle valid strobe. It replaces ad-hoc raw-pin sampling with synchronised, gated, saturating measurement.

---
 rtl/color_freq_sampler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/color_freq_sampler.sv
// color_freq_sampler: steps the colour sensor's S2/S3 filter select through
// red, green, blue and clear, counts synchronised rising edges of the sensor
// frequency output over a fixed gate window for each filter, and publishes
// all four saturating counts together with a one-cycle sample_valid strobe.
// Optional build macro COLOR_SAMPLER_DOMINANT_EN adds a registered
// dominant-colour output and its MIN_CNT threshold parameter.
module color_freq_sampler #(
  parameter int unsigned SETTLE_CYCLES = 10000,
  parameter int unsigned GATE_CYCLES   = 1000000,
`ifdef COLOR_SAMPLER_DOMINANT_EN
  parameter int unsigned MIN_CNT       = 64,
`endif
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sensor_freq,
  output logic [1:0]       filter_sel,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic             sample_valid,
  output logic             busy,
`ifdef COLOR_SAMPLER_DOMINANT_EN
  output logic [1:0]       dominant,
`endif
  output logic [3:0]       ovf
);

  // A zero settle time still spends one cycle in SETTLE.
  localparam int unsigned SETTLE_LD = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam int unsigned GATE_LD   = (GATE_CYCLES == 0) ? 0 : GATE_CYCLES - 1;
  localparam int unsigned TMR_MAX   = (SETTLE_LD > GATE_LD) ? SETTLE_LD : GATE_LD;
  localparam int unsigned TMR_W     = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

  state_t           state;
  logic [1:0]       chan;
  logic [TMR_W-1:0] tmr;
  logic             sync1, sync2, prev;
  logic             edge_det;
  logic [CNT_W-1:0] work_cnt, work_nxt;
  logic             work_ovf, work_ovf_nxt;
  logic [CNT_W-1:0] red_sh, green_sh, blue_sh;
  logic [2:0]       ovf_sh;

  // Filter codes {S2,S3} in the fixed red, green, blue, clear order.
  function automatic logic [1:0] sel_code(input logic [1:0] c);
    case (c)
      2'd0:    sel_code = 2'b00;
      2'd1:    sel_code = 2'b11;
      2'd2:    sel_code = 2'b01;
      default: sel_code = 2'b10;
    endcase
  endfunction

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sensor_freq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = sync2 & ~prev;

  // Saturating increment; ovf marks an edge lost because the count was full.
  always_comb begin
    work_nxt     = work_cnt;
    work_ovf_nxt = work_ovf;
    if (edge_det) begin
      if (work_cnt == CNT_MAX) work_ovf_nxt = 1'b1;
      else                     work_nxt     = work_cnt + 1'b1;
    end
  end

`ifdef COLOR_SAMPLER_DOMINANT_EN
  localparam logic [31:0] MIN_THR = MIN_CNT;
  logic [1:0] dom_calc;

  // Largest of red/green/blue with red > green > blue on ties; none if all below threshold.
  always_comb begin
    dom_calc = 2'b00;
    if ((32'(red_sh) >= MIN_THR) || (32'(green_sh) >= MIN_THR) || (32'(blue_sh) >= MIN_THR)) begin
      if ((red_sh >= green_sh) && (red_sh >= blue_sh)) dom_calc = 2'b01;
      else if (green_sh >= blue_sh)                   dom_calc = 2'b10;
      else                                            dom_calc = 2'b11;
    end
  end
`endif

  // Sequencer: settle, gate and latch each channel, then publish the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      chan         <= 2'd0;
      tmr          <= '0;
      filter_sel   <= 2'b00;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      work_cnt     <= '0;
      work_ovf     <= 1'b0;
      red_sh       <= '0;
      green_sh     <= '0;
      blue_sh      <= '0;
      ovf_sh       <= 3'b000;
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
      clear_cnt    <= '0;
      ovf          <= 4'b0000;
`ifdef COLOR_SAMPLER_DOMINANT_EN
      dominant     <= 2'b00;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            chan       <= 2'd0;
            filter_sel <= sel_code(2'd0);
            tmr        <= TMR_W'(SETTLE_LD);
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            tmr      <= TMR_W'(GATE_LD);
            work_cnt <= '0;
            work_ovf <= 1'b0;
            state    <= GATE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GATE: begin
          work_cnt <= work_nxt;
          work_ovf <= work_ovf_nxt;
          if (tmr == '0) begin
            case (chan)
              2'd0: begin red_sh   <= work_nxt; ovf_sh[0] <= work_ovf_nxt; end
              2'd1: begin green_sh <= work_nxt; ovf_sh[1] <= work_ovf_nxt; end
              2'd2: begin blue_sh  <= work_nxt; ovf_sh[2] <= work_ovf_nxt; end
              default: ;
            endcase
            if (chan != 2'd3) begin
              chan       <= chan + 1'b1;
              filter_sel <= sel_code(chan + 1'b1);
              tmr        <= TMR_W'(SETTLE_LD);
              state      <= SETTLE;
            end else begin
              // Clear goes straight to the outputs so the frame lands in the STORE cycle.
              red_cnt      <= red_sh;
              green_cnt    <= green_sh;
              blue_cnt     <= blue_sh;
              clear_cnt    <= work_nxt;
              ovf          <= {work_ovf_nxt, ovf_sh};
              sample_valid <= 1'b1;
`ifdef COLOR_SAMPLER_DOMINANT_EN
              dominant     <= dom_calc;
`endif
              state        <= STORE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          if (run) begin
            chan       <= 2'd0;
            filter_sel <= sel_code(2'd0);
            tmr        <= TMR_W'(SETTLE_LD);
            state      <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
